// File: rtl/key_expansion.sv
// ---------------------------------------------------------------------------
// key_expansion
//
// Purpose: AES-128 round-key generator. One 128-bit round key is advanced per
// request. The four S-box lookups of SubWord(RotWord(w3)) are done one byte
// per cycle through an external, shared combinational S-box. The four-word
// XOR chain is then applied in a single cycle.
//
// Ports:
//   clk             in   1    system clock, rising edge
//   n_rst           in   1    asynchronous active-low reset
//   readk_enable    in   1    strobe: load cipher key from key_in
//   key_in          in   128  cipher key, [127:120] = byte 0
//   read_enable     in   1    strobe: rewind the schedule to round 0
//   keyexp_enable   in   1    level request for the next round key
//   sbox_in         out  8    byte sent to the shared S-box (0 when unused)
//   sbox_out        in   8    S-box result for sbox_in, same cycle
//   round_key       out  128  current round key, w0 = [127:96]
//   round_num       out  4    rounds expanded since rewind, 0..10
//   keyexp_finished out  1    one-cycle pulse when a round-key update completes
//   finished        out  1    high while round_num == 10
// ---------------------------------------------------------------------------
module key_expansion (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         readk_enable,
    input  logic [127:0] key_in,
    input  logic         read_enable,
    input  logic         keyexp_enable,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         keyexp_finished,
    output logic         finished
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        MIX  = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] orig_key_q, orig_key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_num_q, round_num_d;
    logic [1:0]   byte_idx_q, byte_idx_d;
    logic [31:0]  temp_q, temp_d;

    // RotWord of the last word; byte_idx 0 selects its most significant byte.
    logic [31:0] rot_w3;
    logic [4:0]  byte_lsb;
    logic [31:0] t_word;
    logic [31:0] w0_new, w1_new, w2_new, w3_new;

    assign rot_w3   = {key_q[23:0], key_q[31:24]};
    assign byte_lsb = {~byte_idx_q, 3'b000};   // 8 * (3 - byte_idx)

    // XOR chain for the next round key, consumed only in MIX.
    assign t_word = temp_q ^ {rcon_q, 24'h000000};
    assign w0_new = key_q[127:96] ^ t_word;
    assign w1_new = key_q[95:64]  ^ w0_new;
    assign w2_new = key_q[63:32]  ^ w1_new;
    assign w3_new = key_q[31:0]   ^ w2_new;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            orig_key_q  <= '0;
            rcon_q      <= 8'h01;
            round_num_q <= '0;
            byte_idx_q  <= '0;
            temp_q      <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            orig_key_q  <= orig_key_d;
            rcon_q      <= rcon_d;
            round_num_q <= round_num_d;
            byte_idx_q  <= byte_idx_d;
            temp_q      <= temp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        orig_key_d  = orig_key_q;
        rcon_d      = rcon_q;
        round_num_d = round_num_q;
        byte_idx_d  = byte_idx_q;
        temp_d      = temp_q;
        sbox_in     = 8'h00;

        case (state_q)
            IDLE: begin
                if (read_enable) begin
                    key_d       = orig_key_q;
                    round_num_d = '0;
                    rcon_d      = 8'h01;
                end else if (keyexp_enable) begin
                    // At round 10 the schedule saturates: only the pulse is given.
                    if (round_num_q == 4'd10) begin
                        state_d = DONE;
                    end else begin
                        state_d    = SUB;
                        byte_idx_d = '0;
                    end
                end
            end
            SUB: begin
                sbox_in                  = rot_w3[byte_lsb +: 8];
                temp_d[byte_lsb +: 8]    = sbox_out;
                byte_idx_d               = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    state_d = MIX;
                end
            end
            MIX: begin
                key_d       = {w0_new, w1_new, w2_new, w3_new};
                round_num_d = round_num_q + 4'd1;
                rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                state_d     = DONE;
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (read_enable) begin
                    key_d       = orig_key_q;
                    round_num_d = '0;
                    rcon_d      = 8'h01;
                end
                // Wait for the controller to drop its request before re-arming.
                if (!keyexp_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A key load overrides whatever the state machine was doing.
        if (readk_enable) begin
            key_d       = key_in;
            orig_key_d  = key_in;
            round_num_d = '0;
            rcon_d      = 8'h01;
            byte_idx_d  = '0;
            state_d     = IDLE;
        end
    end

    assign round_key       = key_q;
    assign round_num       = round_num_q;
    assign keyexp_finished = (state_q == DONE);
    assign finished        = (round_num_q == 4'd10);

endmodule
